// File: rtl/mips_pkg.sv
// Shared MIPS core constants: HI/LO unit operation encodings, FSM state
// encoding and the fixed iteration count of the multiply/divide datapath.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;

    localparam int ITERATIONS = 32;

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage <-> HI/LO unit signal bundle; master is the pipeline side,
// slave is the multiply/divide unit.
interface mult_div_unit_if;

    logic        start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        flush;
    logic        MTHI;
    logic        MTLO;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, Op, OperandA, OperandB, flush, MTHI, MTLO,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, Op, OperandA, OperandB, flush, MTHI, MTLO,
        output busy, done, HI, LO
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO
// registers: shift-add multiply, restoring divide, sign fix-up on the last step.
module mult_div_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    logic [0:0]  state_r;
    logic [4:0]  count_r;
    logic [1:0]  op_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic        divzero_r;
    logic [31:0] a_raw_r;
    logic [31:0] b_mag_r;
    logic [63:0] p_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        signed_op_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        is_div_s;
    logic        last_s;
    logic        finish_s;
    logic [32:0] msum_s;
    logic [63:0] mult_next_s;
    logic [32:0] dshift_s;
    logic        ge_s;
    logic [31:0] ddiff_s;
    logic [63:0] div_next_s;
    logic [63:0] p_next_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Operand magnitudes captured at start; signed ops strip the sign here.
    always_comb begin
        signed_op_s = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
        a_neg_s     = signed_op_s & bus.OperandA[31];
        b_neg_s     = signed_op_s & bus.OperandB[31];
        if (a_neg_s) begin
            a_mag_s = 32'd0 - bus.OperandA;
        end else begin
            a_mag_s = bus.OperandA;
        end
        if (b_neg_s) begin
            b_mag_s = 32'd0 - bus.OperandB;
        end else begin
            b_mag_s = bus.OperandB;
        end
    end

    // One datapath iteration: p_r holds {acc, multiplier} or {rem, dividend/quotient}.
    always_comb begin
        is_div_s    = (op_r == OP_DIV) || (op_r == OP_DIVU);
        last_s      = (count_r == 5'(ITERATIONS - 1));
        finish_s    = (state_r == ST_BUSY) && !bus.flush && last_s;
        msum_s      = {1'b0, p_r[63:32]} + (p_r[0] ? {1'b0, b_mag_r} : 33'd0);
        mult_next_s = {msum_s, p_r[31:1]};
        dshift_s    = {p_r[63:32], p_r[31]};
        ge_s        = (dshift_s >= {1'b0, b_mag_r});
        // The true difference is below the divisor, so 32 bits hold it exactly.
        ddiff_s     = dshift_s[31:0] - b_mag_r;
        if (ge_s) begin
            div_next_s = {ddiff_s, p_r[30:0], 1'b1};
        end else begin
            div_next_s = {dshift_s[31:0], p_r[30:0], 1'b0};
        end
        if (is_div_s) begin
            p_next_s = div_next_s;
        end else begin
            p_next_s = mult_next_s;
        end
    end

    // Sign correction of the final iteration's result into HI/LO values.
    always_comb begin
        prod_s   = 64'd0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        if (!is_div_s) begin
            if (sign_a_r ^ sign_b_r) begin
                prod_s = 64'd0 - p_next_s;
            end else begin
                prod_s = p_next_s;
            end
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (divzero_r) begin
            res_hi_s = a_raw_r;
            res_lo_s = 32'hFFFF_FFFF;
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                res_lo_s = 32'd0 - p_next_s[31:0];
            end else begin
                res_lo_s = p_next_s[31:0];
            end
            if (sign_a_r) begin
                res_hi_s = 32'd0 - p_next_s[63:32];
            end else begin
                res_hi_s = p_next_s[63:32];
            end
        end
    end

    // Control FSM and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= 5'd0;
            op_r      <= 2'b00;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            divzero_r <= 1'b0;
            a_raw_r   <= 32'd0;
            b_mag_r   <= 32'd0;
            p_r       <= 64'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start && !bus.flush) begin
                        state_r   <= ST_BUSY;
                        busy_r    <= 1'b1;
                        count_r   <= 5'd0;
                        op_r      <= bus.Op;
                        sign_a_r  <= a_neg_s;
                        sign_b_r  <= b_neg_s;
                        divzero_r <= (bus.OperandB == 32'd0);
                        a_raw_r   <= bus.OperandA;
                        b_mag_r   <= b_mag_s;
                        p_r       <= {32'd0, a_mag_s};
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (last_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        p_r     <= p_next_s;
                    end else begin
                        p_r     <= p_next_s;
                        count_r <= count_r + 5'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Architectural HI/LO: completion wins in BUSY, MTHI/MTLO only in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (finish_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (state_r == ST_IDLE) begin
            if (bus.MTHI) begin
                hi_r <= bus.OperandA;
            end
            if (bus.MTLO) begin
                lo_r <= bus.OperandA;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results,
// MTHI/MTLO interaction, start-while-busy, flush and reset aborts.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.MTHI     = 1'b0;
        bus.MTLO     = 1'b0;
        bus.Op       = 2'b00;
        bus.OperandA = 32'd0;
        bus.OperandB = 32'd0;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen, output bit busy_ok);
        seen    = 1'b0;
        busy_ok = 1'b1;
        cyc     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        total++; if (bus.HI !== 32'd0) begin bad++; $display("FAIL reset_hi got %h want 00000000", bus.HI); end
        total++; if (bus.LO !== 32'd0) begin bad++; $display("FAIL reset_lo got %h want 00000000", bus.LO); end
    endtask

    task automatic test_ops();
        int cyc;
        bit seen;
        bit busy_ok;
        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg"};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[2] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_carry"};
        vecs[3] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, "mult_negb"};
        vecs[4] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_nega"};
        vecs[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb"};
        vecs[6] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, "divu_zero"};
        vecs[7] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero"};
        vecs[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
        vecs[9] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_rem"};
        for (int v = 0; v < 10; v++) begin
            launch(vecs[v].op, vecs[v].a, vecs[v].b);
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got %b want 1", vecs[v].name, bus.busy); end
            wait_done(cyc, seen, busy_ok);
            total++; if (!seen || cyc != 32) begin bad++; $display("FAIL %s latency got seen=%0d cyc=%0d want cyc=32", vecs[v].name, seen, cyc); end
            total++; if (!busy_ok) begin bad++; $display("FAIL %s busy_window got irregular want 32 cycles", vecs[v].name); end
            total++; if (bus.HI !== vecs[v].hi) begin bad++; $display("FAIL %s hi got %h want %h", vecs[v].name, bus.HI, vecs[v].hi); end
            total++; if (bus.LO !== vecs[v].lo) begin bad++; $display("FAIL %s lo got %h want %h", vecs[v].name, bus.LO, vecs[v].lo); end
            @(posedge clk);
            #1;
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s done_pulse got %b want 0", vecs[v].name, bus.done); end
        end
    endtask

    task automatic test_mt_with_start();
        int cyc;
        bit seen;
        bit busy_ok;
        bus.MTHI = 1'b1;
        launch(2'b11, 32'h0000_0064, 32'h0000_0007);
        bus.MTHI = 1'b0;
        total++; if (bus.HI !== 32'h0000_0064) begin bad++; $display("FAIL mt_start_hi got %h want 00000064", bus.HI); end
        wait_done(cyc, seen, busy_ok);
        total++; if (!seen || cyc != 32) begin bad++; $display("FAIL mt_start_latency got cyc=%0d want 32", cyc); end
        total++; if (bus.HI !== 32'h0000_0002 || bus.LO !== 32'h0000_000E) begin
            bad++; $display("FAIL mt_start_result got %h_%h want 00000002_0000000e", bus.HI, bus.LO);
        end
    endtask

    task automatic test_flush();
        bit done_seen;
        bus.OperandA = 32'h0000_1234; bus.MTHI = 1'b1;
        @(posedge clk); #1;
        bus.OperandA = 32'h0000_ABCD; bus.MTHI = 1'b0; bus.MTLO = 1'b1;
        @(posedge clk); #1;
        bus.MTLO = 1'b0;
        total++; if (bus.HI !== 32'h0000_1234 || bus.LO !== 32'h0000_ABCD) begin
            bad++; $display("FAIL mthi_mtlo got %h_%h want 00001234_0000abcd", bus.HI, bus.LO);
        end
        launch(2'b11, 32'h0000_0064, 32'h0000_0003);
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus.start = (k == 5);
            bus.MTHI  = (k == 5);
            bus.MTLO  = (k == 5);
            bus.flush = (k == 10);
            if (k == 5) begin
                bus.Op = 2'b01; bus.OperandA = 32'h5555_5555; bus.OperandB = 32'h0000_0009;
            end
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        idle_inputs();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got %b want 0", bus.busy); end
        total++; if (bus.HI !== 32'h0000_1234) begin bad++; $display("FAIL flush_hi got %h want 00001234", bus.HI); end
        total++; if (bus.LO !== 32'h0000_ABCD) begin bad++; $display("FAIL flush_lo got %h want 0000abcd", bus.LO); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        total++; if (done_seen) begin bad++; $display("FAIL flush_no_done got activity want none"); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        bit busy_ok;
        launch(2'b11, 32'h0000_0064, 32'h0000_0007);
        cyc  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            bus.start = (k == 5);
            if (k == 5) begin
                bus.Op = 2'b01; bus.OperandA = 32'hFFFF_FFFF; bus.OperandB = 32'h0000_0001;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1; cyc = k;
                break;
            end
        end
        total++; if (!seen || cyc != 32) begin bad++; $display("FAIL restart_latency got cyc=%0d want 32", cyc); end
        total++; if (bus.HI !== 32'h0000_0002 || bus.LO !== 32'h0000_000E) begin
            bad++; $display("FAIL restart_result got %h_%h want 00000002_0000000e", bus.HI, bus.LO);
        end
        launch(2'b01, 32'h0000_0003, 32'h0000_0005);
        wait_done(cyc, seen, busy_ok);
        total++; if (!seen || cyc != 32 || !busy_ok) begin bad++; $display("FAIL b2b_latency got cyc=%0d want 32", cyc); end
        total++; if (bus.HI !== 32'd0 || bus.LO !== 32'h0000_000F) begin
            bad++; $display("FAIL b2b_result got %h_%h want 00000000_0000000f", bus.HI, bus.LO);
        end
    endtask

    task automatic test_start_flush();
        bit act;
        bus.flush = 1'b1;
        launch(2'b00, 32'h0000_0002, 32'h0000_0003);
        bus.flush = 1'b0;
        act = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_flush_busy got %b want 0", bus.busy); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) act = 1'b1;
        end
        total++; if (act) begin bad++; $display("FAIL start_flush_idle got activity want none"); end
        total++; if (bus.HI !== 32'd0 || bus.LO !== 32'h0000_000F) begin
            bad++; $display("FAIL start_flush_hilo got %h_%h want 00000000_0000000f", bus.HI, bus.LO);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        done_seen = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        total++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            bad++; $display("FAIL midreset_hilo got %h_%h want 00000000_00000000", bus.HI, bus.LO);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        total++; if (done_seen) begin bad++; $display("FAIL midreset_no_done got pulse want none"); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_ops();
        test_mt_with_start();
        test_flush();
        test_back_to_back();
        test_start_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
